// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter in front of the single register-file write port.
// Clients request writes with a valid/ready handshake; one winner per cycle
// is forwarded to the registered write port one cycle after acceptance.
// A clear request walks every register address writing zero, during which
// no client is accepted and the round-robin pointer is left untouched.
module regfile_write_arbiter #(
  parameter int Bit_Width        = 16,
  parameter int Number_Registers = 8,
  parameter int Register_Select  = 3,
  parameter int Num_Requesters   = 4,
  localparam int GW = (Num_Requesters > 1) ? $clog2(Num_Requesters) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [Num_Requesters-1:0]             Req_Valid,
  output logic [Num_Requesters-1:0]             Req_Ready,
  input  logic [Num_Requesters*Register_Select-1:0] Req_Dest,
  input  logic [Num_Requesters*Bit_Width-1:0]   Req_Data,
  input  logic                                  Clear_Start,
  output logic                                  Clear_Busy,
  output logic                                  Clear_Done,
  output logic                                  Write_Enable,
  output logic [Register_Select-1:0]            Write_Destination,
  output logic [Bit_Width-1:0]                  Data_Destination,
  output logic [GW-1:0]                         Grant_Id
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [GW-1:0]              ptr_q, ptr_d;
  logic [Register_Select-1:0] cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic [Register_Select-1:0] dest_q, dest_d;
  logic [Bit_Width-1:0]       data_q, data_d;
  logic [GW-1:0]              gid_q, gid_d;
  logic                       done_q, done_d;

  logic                       found_s;
  logic [GW-1:0]              winner_s;
  logic [Num_Requesters-1:0]  ready_s;
  logic                       grant_s;

  logic [Register_Select-1:0] dest_arr_s [Num_Requesters];
  logic [Bit_Width-1:0]       data_arr_s [Num_Requesters];

  // Client index that follows v, wrapping at the last client (handles non power-of-two counts).
  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    logic [GW-1:0] r;
    if (v == GW'(Num_Requesters - 1)) begin
      r = '0;
    end else begin
      r = v + GW'(1);
    end
    return r;
  endfunction

  // Client index located off positions after base, wrapping around the client count.
  function automatic logic [GW-1:0] idx_at(input logic [GW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= Num_Requesters) begin
      s = s - Num_Requesters;
    end else begin
      s = s;
    end
    return GW'(s);
  endfunction

  // Unpack the flat per-client payload buses into indexable arrays.
  for (genvar g = 0; g < Num_Requesters; g++) begin : g_unpack
    assign dest_arr_s[g] = Req_Dest[g*Register_Select +: Register_Select];
    assign data_arr_s[g] = Req_Data[g*Bit_Width +: Bit_Width];
  end

  // Round-robin search: first valid client starting at the pointer.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int off = 0; off < Num_Requesters; off++) begin
      if (!found_s && Req_Valid[idx_at(ptr_q, off)]) begin
        found_s  = 1'b1;
        winner_s = idx_at(ptr_q, off);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Ready is one-hot to the winner only in ARB when no clear is being requested.
  always_comb begin
    ready_s = '0;
    if (state_q == ST_ARB && !Clear_Start && found_s) begin
      ready_s[winner_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign grant_s   = |(ready_s & Req_Valid);
  assign Req_Ready = ready_s;

  // Next-state logic: client grants in ARB, address walk writing zeros in CLEAR.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    dest_d  = dest_q;
    data_d  = data_q;
    gid_d   = gid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (Clear_Start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (grant_s) begin
          we_d   = 1'b1;
          dest_d = dest_arr_s[winner_s];
          data_d = data_arr_s[winner_s];
          gid_d  = winner_s;
          ptr_d  = wrap_inc(winner_s);
        end else begin
          we_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        we_d   = 1'b1;
        dest_d = cnt_q;
        data_d = '0;
        if (cnt_q == Register_Select'(Number_Registers - 1)) begin
          state_d = ST_ARB;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + Register_Select'(1);
        end
      end
      default: begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end
    endcase
  end

  // State and write-port registers; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      done_q  <= done_d;
    end
  end

  assign Write_Enable      = we_q;
  assign Write_Destination = dest_q;
  assign Data_Destination  = data_q;
  assign Grant_Id          = gid_q;
  assign Clear_Done        = done_q;
  assign Clear_Busy        = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a transaction-level model predicts
// every output each cycle, and literal expectations pin the key scenarios.
module tb_regfile_write_arbiter;

  localparam int BW = 16;
  localparam int NREG = 8;
  localparam int RS = 3;
  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  Req_Valid;
  logic [N-1:0]  Req_Ready;
  logic [N*RS-1:0] Req_Dest;
  logic [N*BW-1:0] Req_Data;
  logic          Clear_Start;
  logic          Clear_Busy;
  logic          Clear_Done;
  logic          Write_Enable;
  logic [RS-1:0] Write_Destination;
  logic [BW-1:0] Data_Destination;
  logic [1:0]    Grant_Id;

  regfile_write_arbiter #(
    .Bit_Width(BW), .Number_Registers(NREG), .Register_Select(RS), .Num_Requesters(N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Dest(Req_Dest), .Req_Data(Req_Data), .Clear_Start(Clear_Start),
    .Clear_Busy(Clear_Busy), .Clear_Done(Clear_Done), .Write_Enable(Write_Enable),
    .Write_Destination(Write_Destination), .Data_Destination(Data_Destination),
    .Grant_Id(Grant_Id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_clear = 1'b0;
  int          m_win;
  logic        exp_we = 1'b0;
  logic [2:0]  exp_dest = 3'd0;
  logic [15:0] exp_data = 16'd0;
  logic [1:0]  exp_gid = 2'd0;
  logic        exp_done = 1'b0;

  // First valid client at or after the pointer, modulo the client count; -1 if none.
  always_comb begin
    m_win = -1;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (Req_Valid[idx[1:0]]) m_win = idx;
    end
  end

  // Model state update at each clock edge (async reset mirrors the port).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear <= 1'b0; m_cnt <= 0; m_ptr <= 0;
      exp_we <= 1'b0; exp_dest <= 3'd0; exp_data <= 16'd0; exp_gid <= 2'd0; exp_done <= 1'b0;
    end else if (m_clear) begin
      exp_we   <= 1'b1;
      exp_dest <= m_cnt[2:0];
      exp_data <= 16'd0;
      exp_done <= (m_cnt == NREG - 1);
      m_clear  <= (m_cnt != NREG - 1);
      m_cnt    <= (m_cnt == NREG - 1) ? 0 : m_cnt + 1;
    end else begin
      exp_done <= 1'b0;
      if (Clear_Start) begin
        m_clear <= 1'b1;
        exp_we  <= 1'b0;
      end else if (m_win >= 0) begin
        exp_we   <= 1'b1;
        exp_dest <= 3'(Req_Dest >> (RS * m_win));
        exp_data <= 16'(Req_Data >> (BW * m_win));
        exp_gid  <= 2'(m_win);
        m_ptr    <= (m_win + 1) % N;
      end else begin
        exp_we <= 1'b0;
      end
    end
  end

  // Register file fed by the write port.
  logic [15:0] rf [NREG];
  initial for (int i = 0; i < NREG; i++) rf[i] = 16'hDEAD;
  always @(posedge clk) if (Write_Enable) rf[Write_Destination] <= Data_Destination;

  // Per-cycle comparison of every output against the model; also record handshakes.
  logic [N-1:0] acc = '0;
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (!m_clear && !Clear_Start && m_win >= 0) exp_rdy[m_win[1:0]] = 1'b1;
    acc = Req_Valid & Req_Ready;
    check("ready", 32'(Req_Ready), 32'(exp_rdy));
    check("we", 32'(Write_Enable), 32'(exp_we));
    check("dest", 32'(Write_Destination), 32'(exp_dest));
    check("data", 32'(Data_Destination), 32'(exp_data));
    check("gid", 32'(Grant_Id), 32'(exp_gid));
    check("busy", 32'(Clear_Busy), 32'(m_clear));
    check("done", 32'(Clear_Done), 32'(exp_done));
  end

  // ---------------- stimulus ----------------
  logic [18:0] cq [N][$];
  logic        clr_next = 1'b0;

  task automatic push(input int c, input logic [2:0] d, input logic [15:0] v);
    cq[c].push_back({d, v});
  endtask

  // Advance one clock and present the next client state.
  task automatic step();
    logic [18:0] it;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && cq[i].size() > 0) it = cq[i].pop_front();
      Req_Valid[i] = (cq[i].size() > 0);
      if (cq[i].size() > 0) begin
        it = cq[i][0];
        Req_Dest[i*RS +: RS] = it[18:16];
        Req_Data[i*BW +: BW] = it[15:0];
      end
    end
    Clear_Start = clr_next;
  endtask

  initial begin
    int          gseq [8];
    int          exp3 [8];
    int          wes;
    int          nr;
    int          dc;
    logic [3:0]  rdy [$];
    logic [15:0] exp_rf [NREG];

    rst_n = 1'b0; Req_Valid = '0; Req_Dest = '0; Req_Data = '0; Clear_Start = 1'b0;
    exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Test 1: reset state, idle for 10 cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(Write_Enable), 32'd0);
    check("rst_busy", 32'(Clear_Busy), 32'd0);
    check("rst_gid", 32'(Grant_Id), 32'd0);
    rst_n = 1'b1;
    wes = 0;
    for (int j = 0; j < 10; j++) begin
      step(); #2;
      wes += int'(Write_Enable);
      if (Req_Ready != 4'd0) wes += 100;
    end
    check("idle_we_ready", 32'(wes), 32'd0);

    // Test 3: all four clients continuously valid -> 0,1,2,3,0,1,2,3
    for (int j = 0; j < 2; j++)
      for (int c = 0; c < N; c++) push(c, 3'(c * 2 + j), 16'(16'h0100 * c + j + 1));
    step();
    wes = 0;
    for (int j = 0; j < 8; j++) begin
      step(); #2;
      gseq[j] = int'(Grant_Id);
      wes += int'(Write_Enable);
    end
    for (int j = 0; j < 8; j++) check("rr_order", 32'(gseq[j]), 32'(exp3[j]));
    check("rr_we_held", 32'(wes), 32'd8);
    repeat (2) step();

    // Test 4: clear while clients 1 and 3 wait
    push(1, 3'd1, 16'h1111);
    push(3, 3'd6, 16'h3333);
    clr_next = 1'b1;
    step(); #2;
    clr_next = 1'b0;
    check("clr_start_ready", 32'(Req_Ready), 32'd0);
    nr = 1; dc = 0;
    for (int j = 0; j < 30; j++) begin
      step(); #2;
      if (Clear_Done) dc++;
      if (Req_Ready != 4'd0) begin
        rdy.push_back(Req_Ready);
        if (rdy.size() == 2) break;
      end else if (rdy.size() == 0) begin
        nr++;
      end
    end
    check("clr_noready_cycles", 32'(nr), 32'd9);
    check("clr_done_pulses", 32'(dc), 32'd1);
    check("clr_grants_seen", 32'(rdy.size()), 32'd2);
    if (rdy.size() == 2) begin
      check("clr_first_grant", 32'(rdy[0]), 32'b0010);
      check("clr_second_grant", 32'(rdy[1]), 32'b1000);
    end
    repeat (3) step();
    for (int i = 0; i < NREG; i++) exp_rf[i] = 16'h0000;
    exp_rf[1] = 16'h1111;
    exp_rf[6] = 16'h3333;
    for (int i = 0; i < NREG; i++) check("clr_rf", 32'(rf[i]), 32'(exp_rf[i]));

    // Test 2: single client 2 writes reg 5
    push(2, 3'd5, 16'h0015);
    step(); #2;
    check("t2_ready", 32'(Req_Ready), 32'b0100);
    step(); #2;
    check("t2_we", 32'(Write_Enable), 32'd1);
    check("t2_dest", 32'(Write_Destination), 32'd5);
    check("t2_data", 32'(Data_Destination), 32'h0015);
    check("t2_gid", 32'(Grant_Id), 32'd2);
    step();
    check("t2_rf5", 32'(rf[5]), 32'h0015);
    repeat (2) step();

    // Test 6: clients 0 and 1 both target reg 2; later grant wins
    push(0, 3'd2, 16'hAAAA);
    push(1, 3'd2, 16'h5555);
    step();
    step(); #2;
    check("t6_first_gid", 32'(Grant_Id), 32'd0);
    check("t6_first_data", 32'(Data_Destination), 32'hAAAA);
    step(); #2;
    check("t6_second_gid", 32'(Grant_Id), 32'd1);
    check("t6_second_we", 32'(Write_Enable), 32'd1);
    step();
    check("t6_rf2", 32'(rf[2]), 32'h5555);
    repeat (2) step();

    // Test 5: reset during the 4th clear write
    clr_next = 1'b1;
    step();
    clr_next = 1'b0;
    repeat (5) step();
    check("t5_fourth_we", 32'(Write_Enable), 32'd1);
    check("t5_fourth_dest", 32'(Write_Destination), 32'd3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_we", 32'(Write_Enable), 32'd0);
    check("t5_rst_busy", 32'(Clear_Busy), 32'd0);
    check("t5_rst_dest", 32'(Write_Destination), 32'd0);
    dc = 0;
    repeat (2) @(posedge clk);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step(); #2;
      if (Clear_Done) dc++;
    end
    check("t5_no_done", 32'(dc), 32'd0);
    push(0, 3'd7, 16'h7777);
    step(); #2;
    check("t5_ready0", 32'(Req_Ready), 32'b0001);
    step(); #2;
    check("t5_we", 32'(Write_Enable), 32'd1);
    check("t5_gid", 32'(Grant_Id), 32'd0);
    check("t5_data", 32'(Data_Destination), 32'h7777);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
